// File: rtl/mips_dmem_pkg.sv
// mips_dmem_pkg: MMIO addresses and STATUS bit positions shared by the data-memory block
package mips_dmem_pkg;
  localparam logic [7:0] ADDR_TXDATA = 8'hF0;
  localparam logic [7:0] ADDR_STATUS = 8'hF1;
  localparam logic [7:0] ADDR_CNT_LO = 8'hF2;
  localparam logic [7:0] ADDR_CNT_HI = 8'hF3;
  localparam int ST_OVF     = 7;
  localparam int ST_FULL    = 6;
  localparam int ST_EMPTY   = 5;
  localparam int ST_CNT_MSB = 4;
endpackage

// File: rtl/mips_tx_fifo.sv
// mips_tx_fifo: TX byte FIFO; a push into a full FIFO is accepted when a pop happens in the same cycle
module mips_tx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [4:0] count,
  output logic       full,
  output logic       empty,
  output logic [7:0] head
);
  localparam int AW = $clog2(DEPTH);
  logic [7:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign empty   = count == 5'd0;
  assign full    = count == 5'(DEPTH);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? 8'h00 : mem_q[rd_ptr];
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(do_push);
      rd_ptr <= rd_ptr + AW'(do_pop);
      count  <= count + 5'(do_push) - 5'(do_pop);
    end
  end
  always_ff @(posedge clk) if (do_push) mem_q[wr_ptr] <= push_data;
endmodule

// File: rtl/mips_dmem.sv
// mips_dmem: byte RAM below MMIO_BASE plus MMIO TX FIFO/STATUS window; optional cycle counter via MIPS_DMEM_CYCLE_CNT_EN
module mips_dmem
  import mips_dmem_pkg::*;
#(
  parameter int         FIFO_DEPTH = 4,
  parameter logic [7:0] MMIO_BASE  = 8'hF0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       breq,
  input  logic       mem_w_en,
  input  logic [7:0] mem_rw_addr,
  input  logic [7:0] mem_w,
  output logic [7:0] mem_r,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready
);
  logic [7:0] ram [MMIO_BASE];
  logic rd, wr, is_ram, tx_push, tx_pop, full, empty, ovf;
  logic [4:0] count;
  logic [7:0] status, rd_data, cnt_lo, cnt_hi;
  assign rd       = breq && !mem_w_en;
  assign wr       = breq && mem_w_en;
  assign is_ram   = mem_rw_addr < MMIO_BASE;
  assign tx_push  = wr && mem_rw_addr == ADDR_TXDATA;
  assign tx_valid = !empty;
  assign tx_pop   = tx_valid && tx_ready;
  mips_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(tx_push), .push_data(mem_w), .pop(tx_pop),
    .count(count), .full(full), .empty(empty), .head(tx_data)
  );
  always_comb begin
    status = '0;
    status[ST_OVF] = ovf;
    status[ST_FULL] = full;
    status[ST_EMPTY] = empty;
    status[ST_CNT_MSB:0] = count;
  end
`ifdef MIPS_DMEM_CYCLE_CNT_EN
  logic [15:0] cyc;
  logic [7:0] shadow;
  assign cnt_lo = cyc[7:0];
  assign cnt_hi = shadow;
  // HI byte is captured on the LO read so a LO-then-HI pair is coherent
  always_ff @(posedge clk) begin
    cyc    <= rst ? 16'h0000 : cyc + 16'h0001;
    shadow <= rst ? 8'h00 : (rd && mem_rw_addr == ADDR_CNT_LO) ? cyc[15:8] : shadow;
  end
`else
  assign cnt_lo = 8'h00;
  assign cnt_hi = 8'h00;
`endif
  assign rd_data = is_ram ? ram[mem_rw_addr] :
                   mem_rw_addr == ADDR_STATUS ? status :
                   mem_rw_addr == ADDR_CNT_LO ? cnt_lo :
                   mem_rw_addr == ADDR_CNT_HI ? cnt_hi : 8'h00;
  // set beats clear if both ever coincide
  always_ff @(posedge clk) begin
    mem_r <= (rst || !rd) ? 8'h00 : rd_data;
    ovf   <= rst ? 1'b0 :
             (tx_push && full && !tx_pop) ? 1'b1 :
             (wr && mem_rw_addr == ADDR_STATUS && mem_w[0]) ? 1'b0 : ovf;
  end
  always_ff @(posedge clk) if (wr && is_ram) ram[mem_rw_addr] <= mem_w;
endmodule

// File: tb/tb_mips_dmem.sv
// tb_mips_dmem: directed self-checking bench for mips_dmem (counter expectations follow MIPS_DMEM_CYCLE_CNT_EN)
module tb_mips_dmem;
  logic clk = 0, rst = 0, breq = 0, mem_w_en = 0, tx_valid, tx_ready = 0;
  logic [7:0] mem_rw_addr = 0, mem_w = 0, mem_r, tx_data;
  int passed = 0, total = 0;

  mips_dmem dut (
    .clk(clk), .rst(rst), .breq(breq), .mem_w_en(mem_w_en), .mem_rw_addr(mem_rw_addr),
    .mem_w(mem_w), .mem_r(mem_r), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    breq = 1; mem_w_en = 1; mem_rw_addr = a; mem_w = d;
    step();
    breq = 0; mem_w_en = 0;
  endtask

  task automatic rd(input logic [7:0] a);
    breq = 1; mem_w_en = 0; mem_rw_addr = a;
    step();
    breq = 0;
  endtask

  task automatic test_reset();
    rst = 1; step(); step(); rst = 0;
    total++; if (mem_r !== 8'h00) $display("FAIL reset_mem_r got %h want 00", mem_r); else passed++;
    total++; if (tx_valid !== 1'b0) $display("FAIL reset_tx_valid got %b want 0", tx_valid); else passed++;
    total++; if (tx_data !== 8'h00) $display("FAIL reset_tx_data got %h want 00", tx_data); else passed++;
    rd(8'hF1);
    total++; if (mem_r !== 8'h20) $display("FAIL reset_status got %h want 20", mem_r); else passed++;
  endtask

  task automatic test_ram();
    wr(8'h10, 8'h5A); rd(8'h10);
    total++; if (mem_r !== 8'h5A) $display("FAIL ram_read got %h want 5a", mem_r); else passed++;
    step();
    total++; if (mem_r !== 8'h00) $display("FAIL ram_idle got %h want 00", mem_r); else passed++;
    wr(8'hEF, 8'h77); rd(8'hEF);
    total++; if (mem_r !== 8'h77) $display("FAIL ram_top got %h want 77", mem_r); else passed++;
    wr(8'hF5, 8'h33); rd(8'hF5);
    total++; if (mem_r !== 8'h00) $display("FAIL mmio_unused got %h want 00", mem_r); else passed++;
    rd(8'hF0);
    total++; if (mem_r !== 8'h00) $display("FAIL txdata_read got %h want 00", mem_r); else passed++;
  endtask

  task automatic test_fill_drain();
    logic [7:0] exp [3] = '{8'h41, 8'h42, 8'h43};
    tx_ready = 0;
    foreach (exp[i]) wr(8'hF0, exp[i]);
    rd(8'hF1);
    total++; if (mem_r !== 8'h03) $display("FAIL fill_status got %h want 03", mem_r); else passed++;
    tx_ready = 1;
    foreach (exp[i]) begin
      total++; if (tx_valid !== 1'b1 || tx_data !== exp[i]) $display("FAIL drain_%0d got %b/%h want 1/%h", i, tx_valid, tx_data, exp[i]); else passed++;
      step();
    end
    total++; if (tx_valid !== 1'b0) $display("FAIL drain_empty got %b want 0", tx_valid); else passed++;
    tx_ready = 0;
    rd(8'hF1);
    total++; if (mem_r !== 8'h20) $display("FAIL drain_status got %h want 20", mem_r); else passed++;
  endtask

  task automatic test_overflow();
    logic [7:0] exp [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    tx_ready = 0;
    foreach (exp[i]) wr(8'hF0, exp[i]);
    rd(8'hF1);
    total++; if (mem_r !== 8'hC4) $display("FAIL ovf_status got %h want c4", mem_r); else passed++;
    wr(8'hF1, 8'h01); rd(8'hF1);
    total++; if (mem_r !== 8'h44) $display("FAIL ovf_clear got %h want 44", mem_r); else passed++;
    tx_ready = 1;
    for (int i = 0; i < 4; i++) begin
      total++; if (tx_valid !== 1'b1 || tx_data !== exp[i]) $display("FAIL ovf_drain_%0d got %b/%h want 1/%h", i, tx_valid, tx_data, exp[i]); else passed++;
      step();
    end
    total++; if (tx_valid !== 1'b0) $display("FAIL ovf_empty got %b want 0", tx_valid); else passed++;
    tx_ready = 0;
  endtask

  task automatic test_full_push_pop();
    logic [7:0] exp [4] = '{8'hA2, 8'hA3, 8'hA4, 8'h99};
    tx_ready = 0;
    wr(8'hF0, 8'hA1); wr(8'hF0, 8'hA2); wr(8'hF0, 8'hA3); wr(8'hF0, 8'hA4);
    total++; if (tx_data !== 8'hA1) $display("FAIL fpp_head got %h want a1", tx_data); else passed++;
    tx_ready = 1;
    wr(8'hF0, 8'h99);
    tx_ready = 0;
    rd(8'hF1);
    total++; if (mem_r !== 8'h44) $display("FAIL fpp_status got %h want 44", mem_r); else passed++;
    tx_ready = 1;
    foreach (exp[i]) begin
      total++; if (tx_valid !== 1'b1 || tx_data !== exp[i]) $display("FAIL fpp_drain_%0d got %b/%h want 1/%h", i, tx_valid, tx_data, exp[i]); else passed++;
      step();
    end
    total++; if (tx_valid !== 1'b0) $display("FAIL fpp_empty got %b want 0", tx_valid); else passed++;
    tx_ready = 0;
  endtask

  task automatic test_reset_mid();
    wr(8'h20, 8'hC3);
    wr(8'hF0, 8'h01); wr(8'hF0, 8'h02);
    rst = 1; breq = 1; mem_w_en = 0; mem_rw_addr = 8'h20;
    step();
    rst = 0; breq = 0;
    total++; if (tx_valid !== 1'b0) $display("FAIL rstmid_tx_valid got %b want 0", tx_valid); else passed++;
    total++; if (mem_r !== 8'h00) $display("FAIL rstmid_mem_r got %h want 00", mem_r); else passed++;
    rd(8'hF1);
    total++; if (mem_r !== 8'h20) $display("FAIL rstmid_status got %h want 20", mem_r); else passed++;
    rd(8'h20);
    total++; if (mem_r !== 8'hC3) $display("FAIL rstmid_ram got %h want c3", mem_r); else passed++;
  endtask

  task automatic test_counter();
    logic [7:0] exp_lo, exp_hi;
`ifdef MIPS_DMEM_CYCLE_CNT_EN
    exp_lo = 8'hFF; exp_hi = 8'h01;
`else
    exp_lo = 8'h00; exp_hi = 8'h00;
`endif
    rst = 1; step(); rst = 0;
    repeat (511) @(posedge clk);
    #1;
    rd(8'hF2);
    total++; if (mem_r !== exp_lo) $display("FAIL cnt_lo got %h want %h", mem_r, exp_lo); else passed++;
    step(); step(); step();
    rd(8'hF3);
    total++; if (mem_r !== exp_hi) $display("FAIL cnt_hi got %h want %h", mem_r, exp_hi); else passed++;
  endtask

  initial begin
    #1;
    test_reset();
    test_ram();
    test_fill_drain();
    test_overflow();
    test_full_push_pop();
    test_reset_mid();
    test_counter();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
